// File: rtl/pipelined_approx_adder.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// pipelined_approx_adder
//
// Chunked adder: WIDTH-bit operands are split into NCH = WIDTH/CHUNK slices,
// and each slice is added in its own register stage, so there are NCH stages
// in total. Each beat carries its own approximate count E, and
// E = min(approx_chunks, NCH). The lowest E slices use lower-part-OR logic:
// their sum is a|b and they drop any incoming carry. The top approximate
// slice passes the AND of the slice MSBs as its carry, which seeds the exact
// part of the sum.
//
// The pipeline stalls as a whole. Every stage advances when
// en = ~out_valid | out_ready, and holds otherwise. Bubbles are kept in
// the pipeline, not squeezed out.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready == en, combinational)
//   in1, in2, cin        operands and carry-in (cin unused when E > 0)
//   approx_chunks        requested approximate slice count, sampled on accept
//   out_valid/out_ready  result handshake
//   sum, cout            result and carry-out of the top slice
//   approx_flag          the result was produced with E > 0
//   approx_ops           saturating count of approximate output handshakes
// ---------------------------------------------------------------------------
module pipelined_approx_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic [AW-1:0]    approx_chunks,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             approx_flag,
  output logic [15:0]      approx_ops
);

  localparam int          NCH   = WIDTH / CHUNK;
  localparam logic [AW-1:0] NCH_E = AW'(NCH);

  // Per-stage registers. Stage k holds:
  //   s_q : sum bits of slices 0..k; the bits above are still zero
  //   a_q : operand A, carried forward unchanged (slices above k still unused)
  //   b_q : operand B, carried forward unchanged
  //   c_q : carry out of slice k
  //   e_q : effective approximate count for this beat
  //   v_q : stage holds a live beat
  logic [WIDTH-1:0] a_q [NCH];
  logic [WIDTH-1:0] b_q [NCH];
  logic [WIDTH-1:0] s_q [NCH];
  logic             c_q [NCH];
  logic [AW-1:0]    e_q [NCH];
  logic             v_q [NCH];

  // Next-state values each stage would load on an advance.
  logic [WIDTH-1:0] a_d [NCH];
  logic [WIDTH-1:0] b_d [NCH];
  logic [WIDTH-1:0] s_d [NCH];
  logic             c_d [NCH];
  logic [AW-1:0]    e_d [NCH];
  logic             v_d [NCH];

  logic          en;
  logic [AW-1:0] e_clamp;

  assign en        = ~out_valid | out_ready;
  assign in_ready  = en;
  assign e_clamp   = (approx_chunks > NCH_E) ? NCH_E : approx_chunks;

  assign out_valid   = v_q[NCH-1];
  assign sum         = s_q[NCH-1];
  assign cout        = c_q[NCH-1];
  assign approx_flag = (e_q[NCH-1] != '0);

  // Slice datapath for every stage.
  always_comb begin
    logic [WIDTH-1:0] a_i, b_i, s_i;
    logic             c_i, v_i;
    logic [AW-1:0]    e_i;
    logic [CHUNK-1:0] sa, sb, ss;
    logic             sc;
    // NOTE: every variable written here gets a value before any branch, so
    // no path can leave one unassigned and infer a latch.
    a_i = '0; b_i = '0; s_i = '0; c_i = 1'b0; v_i = 1'b0; e_i = '0;
    sa  = '0; sb  = '0; ss  = '0; sc  = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (k == 0) begin
        a_i = in1;
        b_i = in2;
        s_i = '0;
        c_i = cin;
        e_i = e_clamp;
        v_i = in_valid;
      end else begin
        a_i = a_q[k-1];
        b_i = b_q[k-1];
        s_i = s_q[k-1];
        c_i = c_q[k-1];
        e_i = e_q[k-1];
        v_i = v_q[k-1];
      end
      sa = a_i[k*CHUNK +: CHUNK];
      sb = b_i[k*CHUNK +: CHUNK];
      if (k >= int'(e_i)) begin
        {sc, ss} = {1'b0, sa} + {1'b0, sb} + {{CHUNK{1'b0}}, c_i};
      end else begin
        // Approximate slice: ignore the incoming carry. Only the topmost
        // approximate slice feeds a carry (the AND of the slice MSBs) into
        // the exact part above it.
        ss = sa | sb;
        sc = (k + 1 == int'(e_i)) ? (sa[CHUNK-1] & sb[CHUNK-1]) : 1'b0;
      end
      a_d[k] = a_i;
      b_d[k] = b_i;
      e_d[k] = e_i;
      v_d[k] = v_i;
      c_d[k] = sc;
      s_d[k] = s_i;
      s_d[k][k*CHUNK +: CHUNK] = ss;
    end
  end

  // Pipeline registers. Data loads only with a live beat, so bubbles and
  // idle inputs leave the stored operands untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data registers are reset as well as the valid bits, so sum,
      // cout and approx_flag read zero out of reset.
      for (int k = 0; k < NCH; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        e_q[k] <= '0;
        v_q[k] <= 1'b0;
      end
    end else if (en) begin
      for (int k = 0; k < NCH; k++) begin
        // NOTE: non-blocking updates let every stage sample its predecessor's
        // pre-edge value, so beats shift by exactly one stage per edge.
        v_q[k] <= v_d[k];
        if (v_d[k]) begin
          a_q[k] <= a_d[k];
          b_q[k] <= b_d[k];
          s_q[k] <= s_d[k];
          c_q[k] <= c_d[k];
          e_q[k] <= e_d[k];
        end
      end
    end
  end

  // Count approximate results as they are handed downstream, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      approx_ops <= '0;
    end else if (out_valid && out_ready && approx_flag && approx_ops != 16'hFFFF) begin
      approx_ops <= approx_ops + 16'd1;
    end
  end

endmodule
